// File: rtl/mem_copier_pkg.sv
// Shared definitions for the memory copier engine: default widths, the
// all-ones byteenable constant and the FSM state encoding.
package mem_copier_pkg;

    localparam int unsigned MC_ADDR_W = 12;
    localparam int unsigned MC_DATA_W = 32;
    localparam int unsigned MC_LEN_W  = 13;

    // Wide enough to be sliced for any data width up to 1024 bits.
    localparam logic [127:0] MC_BE_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } mc_state_e;

endpackage

// File: rtl/multicore_system_mem_copier_csum.sv
// Running checksum accumulator: clears on clr_i, adds data_i (mod 2^W) on en_i.
// Ports: clk, reset_n, clr_i, en_i, data_i[W], sum_o[W] (registered).
module mem_copier_csum #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] sum_q;

    // Clear has priority; the engine never clears and adds in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_q + data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/multicore_system_mem_copier.sv
// Avalon-MM master block copy / fill engine for one port of a dual-port RAM.
// Command side: cmd_valid/cmd_ready handshake with fill/src/dst/len/pattern,
//   abort request, done pulse with aborted/words_done status, busy.
// Bus side: avm_address/read/write/writedata/byteenable out,
//   avm_waitrequest/readdata/readdatavalid in.
// csum: running sum of written data when built with MEM_COPIER_CSUM_EN,
//   otherwise tied to zero.
module multicore_system_mem_copier
    import mem_copier_pkg::*;
#(
    parameter int unsigned ADDR_W = MC_ADDR_W,
    parameter int unsigned DATA_W = MC_DATA_W,
    parameter int unsigned LEN_W  = MC_LEN_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_fill,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   cmd_pattern,
    input  logic                abort,
    output logic                done,
    output logic                aborted,
    output logic [LEN_W-1:0]    words_done,
    output logic                busy,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [31:0]         csum
);

    localparam int unsigned BE_W = DATA_W / 8;

    mc_state_e           state_q;
    logic                fill_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   pat_q;
    logic [LEN_W-1:0]    i_q;
    logic                abort_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic [LEN_W-1:0]    words_done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                accept_c;
    logic                wr_acc_c;
    logic                abort_now_c;
    logic [LEN_W-1:0]    i_inc_c;
    logic                last_c;

    assign accept_c    = cmd_valid & cmd_ready_q;
    assign wr_acc_c    = (state_q == ST_WR_REQ) & ~avm_waitrequest;
    // An abort raised in the same cycle as a decision point counts immediately.
    assign abort_now_c = abort_q | abort;
    assign i_inc_c     = i_q + LEN_W'(1);
    assign last_c      = (i_inc_c == len_q);

    // Engine FSM; every bus and status output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            fill_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            pat_q        <= '0;
            i_q          <= '0;
            abort_q      <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            words_done_q <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q inside {ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ}) begin
                abort_q <= abort_q | abort;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        fill_q       <= cmd_fill;
                        src_q        <= cmd_src;
                        dst_q        <= cmd_dst;
                        len_q        <= cmd_len;
                        pat_q        <= cmd_pattern;
                        i_q          <= '0;
                        abort_q      <= 1'b0;
                        aborted_q    <= 1'b0;
                        words_done_q <= '0;
                        cmd_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        if (cmd_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (cmd_fill) begin
                            state_q <= ST_WR_REQ;
                            wr_q    <= 1'b1;
                            addr_q  <= cmd_dst;
                            wdata_q <= cmd_pattern;
                        end else begin
                            state_q <= ST_RD_REQ;
                            rd_q    <= 1'b1;
                            addr_q  <= cmd_src;
                        end
                    end
                end
                ST_RD_REQ: begin
                    // A pending abort still lets the issued read complete.
                    if (!avm_waitrequest) begin
                        rd_q    <= 1'b0;
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        if (abort_now_c) begin
                            // Read data is dropped; nothing is written for word i.
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            aborted_q    <= 1'b1;
                            words_done_q <= i_q;
                        end else begin
                            state_q <= ST_WR_REQ;
                            wr_q    <= 1'b1;
                            addr_q  <= dst_q + ADDR_W'(i_q);
                            wdata_q <= avm_readdata;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (wr_acc_c) begin
                        i_q <= i_inc_c;
                        if (last_c || abort_now_c) begin
                            wr_q         <= 1'b0;
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            aborted_q    <= ~last_c;
                            words_done_q <= i_inc_c;
                        end else if (fill_q) begin
                            addr_q <= dst_q + ADDR_W'(i_inc_c);
                        end else begin
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b1;
                            addr_q  <= src_q + ADDR_W'(i_inc_c);
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rd_q        <= 1'b0;
                    wr_q        <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign words_done     = words_done_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = BE_W'(MC_BE_ALL);

`ifdef MEM_COPIER_CSUM_EN
    // Sum of every accepted write, including the one that ends an abort.
    mem_copier_csum #(
        .W (32)
    ) u_csum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (accept_c),
        .en_i    (wr_acc_c),
        .data_i  (32'(wdata_q)),
        .sum_o   (csum)
    );
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_multicore_system_mem_copier.sv
// Self-checking bench for multicore_system_mem_copier: a RAM model with
// optional random waitrequest, a write scoreboard and command-level checks.
module tb_multicore_system_mem_copier;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_fill = 1'b0;
    logic [11:0] cmd_src = '0;
    logic [11:0] cmd_dst = '0;
    logic [12:0] cmd_len = '0;
    logic [31:0] cmd_pattern = '0;
    logic        abort = 1'b0;
    logic        done;
    logic        aborted;
    logic [12:0] words_done;
    logic        busy;
    logic [11:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] csum;

    multicore_system_mem_copier dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_fill          (cmd_fill),
        .cmd_src           (cmd_src),
        .cmd_dst           (cmd_dst),
        .cmd_len           (cmd_len),
        .cmd_pattern       (cmd_pattern),
        .abort             (abort),
        .done              (done),
        .aborted           (aborted),
        .words_done        (words_done),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .csum              (csum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [31:0] mem [0:4095];
    logic        wait_en = 1'b0;
    logic        ignore_wr = 1'b0;
    logic        rd_hit = 1'b0;
    logic [11:0] rd_hit_addr = '0;
    int          rd_cnt = 0;
    int          act_cnt = 0;
    int          wr_cyc = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_addr = '0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_wd = '0;

    // Bus monitor at the falling edge: stall stability, exclusivity, scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall) begin
                chk("stall_addr", avm_address, prev_addr);
                chk("stall_rd", avm_read, prev_rd);
                chk("stall_wr", avm_write, prev_wr);
                chk("stall_wdata", avm_writedata, prev_wd);
            end
            if (avm_read || avm_write) begin
                act_cnt++;
                chk("rd_wr_excl", avm_read & avm_write, 0);
            end
            if (avm_write) wr_cyc++;
            if (done) done_cnt++;
            rd_hit = avm_read && !avm_waitrequest;
            rd_hit_addr = avm_address;
            if (rd_hit) rd_cnt++;
            if (avm_write && !avm_waitrequest && !ignore_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_wr", {avm_address, avm_writedata}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", avm_address, e.a);
                    chk("wr_data", avm_writedata, e.d);
                end
            end
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            prev_addr = avm_address;
            prev_rd = avm_read;
            prev_wr = avm_write;
            prev_wd = avm_writedata;
        end else begin
            prev_stall = 1'b0;
            rd_hit = 1'b0;
        end
    end

    // Slave side: 1-cycle read latency, optional random waitrequest.
    always @(posedge clk) begin
        #1;
        avm_readdatavalid = rd_hit;
        avm_readdata = rd_hit ? mem[rd_hit_addr] : $urandom;
        avm_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    int last_busy;
    int last_wr;
    int last_act;

    task automatic run_cmd(input logic fill, input logic [11:0] src, input logic [11:0] dst,
                           input logic [12:0] len, input logic [31:0] pat, input int abort_rd);
        logic got;
        logic arm;
        int   rd0;
        int   wr0;
        int   act0;
        got = 1'b0;
        arm = (abort_rd > 0);
        last_busy = 0;
        @(negedge clk);
        #1;
        rd0 = rd_cnt;
        wr0 = wr_cyc;
        act0 = act_cnt;
        cmd_fill = fill;
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = len;
        cmd_pattern = pat;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) last_busy++;
            if (arm && (rd_cnt - rd0) == abort_rd) begin
                arm = 1'b0;
                @(negedge clk);
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
            end
        end
        chk("done_seen", got, 1);
        last_wr = wr_cyc - wr0;
        last_act = act_cnt - act0;
    endtask

    function automatic logic [31:0] csum_model(input logic [31:0] s);
`ifdef MEM_COPIER_CSUM_EN
        return s;
`else
        return 32'(s & 32'h0);
`endif
    endfunction

    logic [31:0] sum;
    int          dc0;

    initial begin
        // Reset values
        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_words", words_done, 0);
        chk("rst_rdwr", {avm_read, avm_write}, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_csum", csum, 0);
        chk("rst_be", avm_byteenable, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;

        // Copy 4 words at zero wait states
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            mem[12'h010 + 12'(k)] = 32'hA000_0000 + 32'(k);
            exp_q.push_back('{a: 12'h100 + 12'(k), d: 32'hA000_0000 + 32'(k)});
            sum += 32'hA000_0000 + 32'(k);
        end
        run_cmd(1'b0, 12'h010, 12'h100, 13'd4, 32'h0, 0);
        chk("cp4_busy_cyc", last_busy, 12);
        chk("cp4_words", words_done, 4);
        chk("cp4_aborted", aborted, 0);
        chk("cp4_sb_empty", exp_q.size(), 0);
        chk("cp4_csum", csum, csum_model(sum));
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("words_held", words_done, 4);

        // Fill with address wrap, back-to-back writes
        exp_q.push_back('{a: 12'hFFE, d: 32'hDEADBEEF});
        exp_q.push_back('{a: 12'hFFF, d: 32'hDEADBEEF});
        exp_q.push_back('{a: 12'h000, d: 32'hDEADBEEF});
        run_cmd(1'b1, 12'h0, 12'hFFE, 13'd3, 32'hDEADBEEF, 0);
        chk("fill_busy_cyc", last_busy, 3);
        chk("fill_wr_cyc", last_wr, 3);
        chk("fill_words", words_done, 3);
        chk("fill_sb_empty", exp_q.size(), 0);
        chk("fill_csum", csum, csum_model(32'hDEADBEEF * 32'd3));

        // Copy 8 words under random waitrequest
        sum = '0;
        for (int k = 0; k < 8; k++) begin
            mem[12'h200 + 12'(k)] = $urandom;
            exp_q.push_back('{a: 12'h300 + 12'(k), d: mem[12'h200 + 12'(k)]});
            sum += mem[12'h200 + 12'(k)];
        end
        wait_en = 1'b1;
        run_cmd(1'b0, 12'h200, 12'h300, 13'd8, 32'h0, 0);
        wait_en = 1'b0;
        chk("rw_words", words_done, 8);
        chk("rw_aborted", aborted, 0);
        chk("rw_sb_empty", exp_q.size(), 0);
        chk("rw_csum", csum, csum_model(sum));

        // Copy 10 words, abort while word 5 is in RD_WAIT
        sum = '0;
        for (int k = 0; k < 10; k++) begin
            mem[12'h400 + 12'(k)] = 32'h5500_0000 + 32'(k);
            if (k < 5) begin
                exp_q.push_back('{a: 12'h500 + 12'(k), d: 32'h5500_0000 + 32'(k)});
                sum += 32'h5500_0000 + 32'(k);
            end
        end
        run_cmd(1'b0, 12'h400, 12'h500, 13'd10, 32'h0, 6);
        chk("ab_aborted", aborted, 1);
        chk("ab_words", words_done, 5);
        chk("ab_wr_cyc", last_wr, 5);
        chk("ab_csum", csum, csum_model(sum));
        repeat (4) @(negedge clk);
        #1;
        chk("ab_sb_empty", exp_q.size(), 0);
        chk("ab_aborted_held", aborted, 1);

        // Zero-length command
        run_cmd(1'b0, 12'h123, 12'h456, 13'd0, 32'h0, 0);
        chk("z_busy_cyc", last_busy, 0);
        chk("z_activity", last_act, 0);
        chk("z_words", words_done, 0);
        chk("z_aborted", aborted, 0);

        // Abort in IDLE is ignored; checksum wraps on 4 x 0x40000000
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back('{a: 12'h800 + 12'(k), d: 32'h4000_0000});
        run_cmd(1'b1, 12'h0, 12'h800, 13'd4, 32'h4000_0000, 0);
        chk("cs_aborted", aborted, 0);
        chk("cs_words", words_done, 4);
        chk("cs_csum", csum, 32'h0);
        chk("cs_sb_empty", exp_q.size(), 0);

        // Reset in mid-transfer drops requests, no completion
        ignore_wr = 1'b1;
        dc0 = done_cnt;
        @(negedge clk);
        cmd_fill = 1'b0;
        cmd_src = 12'h010;
        cmd_dst = 12'h900;
        cmd_len = 13'd6;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_rdwr", {avm_read, avm_write}, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", cmd_ready, 1);
        chk("mr_words", words_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("mr_no_done", done_cnt - dc0, 0);
        chk("mr_idle_act", {avm_read, avm_write}, 0);
        ignore_wr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicore_system_mem_copier.md
Name: multicore_system_mem_copier

Overview:
Avalon-MM master engine that drives one slave port of a core's dual-port on-chip RAM (32-bit data, 4096-word space).
It executes block copy (read src, write dst) and block fill (write a constant pattern) commands.
Commands are issued by a simple valid/ready command interface from the core's control logic.
It completes each command with a one-cycle done pulse and a status word count.

Parameters:
- ADDR_W, 12: word address width of the master port (RAM depth 2^ADDR_W).
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- LEN_W, 13: command length width; it can express 0..2^ADDR_W words.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready.
- cmd_fill  in  1  1 = fill, 0 = copy.
- cmd_src  in  ADDR_W  copy source word address (ignored for fill).
- cmd_dst  in  ADDR_W  destination word address.
- cmd_len  in  LEN_W  number of words.
- cmd_pattern  in  DATA_W  fill data.
- abort  in  1  request early termination.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  status of the last command, valid with done and held until the next accept.
- words_done  out  LEN_W  words written by the last command, held until the next accept.
- busy  out  1  command in progress.
- avm_address  out  ADDR_W  word address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid.
- csum  out  32  running checksum (see Optional Feature).

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - cmd_ready=1; busy, done, aborted = 0; words_done=0.
  - avm_read, avm_write = 0; avm_address and avm_writedata = 0; csum=0.
  - Reset mid-transfer drops requests immediately. No completion is reported.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch the command and clear the word counter i and status outputs.
  - len==0 goes to DONE with no bus traffic.
  - Otherwise copy goes to RD_REQ and fill goes to WR_REQ.
- RD_REQ:
  - avm_read=1, avm_address=src+i (mod 2^ADDR_W).
  - avm_read, avm_address are held stable while avm_waitrequest=1.
  - On a cycle with waitrequest=0, go to RD_WAIT.
- RD_WAIT:
  - Bus idle; wait for avm_readdatavalid.
  - On the valid cycle, capture readdata into the data register and go to WR_REQ.
  - readdatavalid outside RD_WAIT is ignored.
- WR_REQ:
  - avm_write=1, avm_address=dst+i (mod 2^ADDR_W).
  - avm_writedata = captured data (copy) or pattern (fill).
  - All bus outputs are held while waitrequest=1.
  - On acceptance, i++.
  - If i==len or abort is pending, go to DONE.
  - Otherwise the next state is RD_REQ (copy) or WR_REQ (fill).
- DONE:
  - done=1 for exactly one cycle; words_done=i.
  - aborted=1 if the command ended by abort.
  - Next state IDLE.
- Abort:
  - Sampled every busy cycle and latched as pending.
  - It never truncates an outstanding bus request (Avalon rule).
  - Pending abort in RD_REQ completes the read. In RD_WAIT it waits for readdatavalid, discards the data and goes to DONE without writing.
  - Abort in IDLE or DONE is ignored.
  - Abort coincident with acceptance of the final write is reported as aborted=0.
- Throughput at zero wait states and 1-cycle read latency: copy = 3 cycles/word; fill = 1 cycle/word (back-to-back writes).
- Overlapping src/dst ranges: copy runs in ascending order only; there is no overlap correction.
- Address wrap at 2^ADDR_W is silent.
- busy = !IDLE.
- avm_read and avm_write are never both 1.

Optional Feature:
MEM_COPIER_CSUM_EN:
- Defined: csum is cleared on command accept, and each accepted write adds avm_writedata (mod 2^32), including the write that triggers abort.
- Undefined: the csum port remains and is tied to 0; no adder is inferred.

Decomposition:
- Package mem_copier_pkg: state encoding (IDLE..DONE), default widths ADDR_W/DATA_W/LEN_W, and the all-ones byteenable constant.
- One natural sub-module, mem_copier_csum: an accumulator with clear/enable, instantiated only under MEM_COPIER_CSUM_EN.

Test Plan:
- Copy len=4, src=0x010, dst=0x100, RAM[0x010..0x013]=A0..A3, zero wait states -> RAM[0x100..0x103]=A0..A3; done after 12 busy cycles; words_done=4, aborted=0.
- Fill len=3, dst=0xFFE, pattern=0xDEADBEEF -> writes to 0xFFE, 0xFFF, 0x000 (wrap); 3 consecutive write cycles; words_done=3.
- Random waitrequest (50%) during copy len=8 -> address, read, write and writedata stable across every stall; data matches; no read+write overlap.
- Copy len=10 with abort pulsed while in RD_WAIT of word 5 (i=5) -> read completes and data is discarded; done with aborted=1, words_done=5; no write to dst+5.
- cmd len=0 -> done the cycle after IDLE->DONE, no avm_read/avm_write activity; words_done=0.
- With MEM_COPIER_CSUM_EN, fill len=4 pattern=0x40000000 -> csum=0x00000000 (wrap). Without the macro, csum stays 0.
